mul_stall_unit: RTL and testbench
=================================

// Module: mul_stall_unit
// PURPOSE
//  Iterative radix-2 shift-add multiplier in the EX stage. Raises the MulOp stall request consumed by the
//  hazard detection unit and holds it until the product is ready, so the pipeline stays frozen meanwhile.
//  Releases the stall for exactly one cycle with done/hi/lo valid; the MULT instruction then leaves EX.
// PARAMETERS
//  WIDTH   32   operand width; product is 2*WIDTH bits (hi = upper WIDTH, lo = lower WIDTH)
// PORTS
//  Clk        in   1      clock, all state updates on rising edge
//  Reset      in   1      synchronous, active-high reset
//  start      in   1      ID/EX carries a multiply; held high by pipeline while stalled
//  signed_op  in   1      1 = two's-complement operands, 0 = unsigned
//  flush      in   1      kill the in-flight multiply (branch/exception flush of EX)
//  a          in   WIDTH  multiplicand (rs value)
//  b          in   WIDTH  multiplier (rt value)
//  stall_req  out  1      MulOp to hazard unit: freeze PC, IF/ID; bubble ID/EX
//  done       out  1      one-cycle strobe, hi/lo valid this cycle
//  hi         out  WIDTH  product upper half
//  lo         out  WIDTH  product lower half
// BEHAVIOUR
//  - Reset (sync, active-high): state=IDLE, hi=lo=0, done=0, counter=0; stall_req forced 0 while Reset=1.
//  - FSM states IDLE, BUSY, DONE.
//    IDLE: start=1 & flush=0 -> latch |a|,|b| (magnitudes if signed_op), sign=a[W-1]^b[W-1]&signed_op,
//          clear accumulator, count=0 -> BUSY. Otherwise stay IDLE.
//    BUSY: each cycle: if mcand-multiplier LSB=1 add shifted multiplicand to 2W accumulator; shift multiplier
//          right, multiplicand left; count++. After WIDTH steps -> DONE. flush=1 -> IDLE, no result.
//    DONE: hi/lo <= sign ? -acc : acc (2W-bit two's complement); done=1 for this cycle; -> IDLE unconditionally
//          (start still high for the same instruction must NOT retrigger).
//  - stall_req = (IDLE & start & ~flush) | BUSY. Combinational so the hazard unit stalls in the issue cycle.
//    stall_req=0 in DONE.
//  - Latency (no early exit): issue cycle C0 stall; BUSY C1..CW stall; DONE at C(W+1). Total W+1 stalled cycles.
//  - hi/lo hold last result until next DONE; never updated on flush or in BUSY.
//  - Width rules: accumulator 2*WIDTH bits, no overflow possible; most-negative operand magnitude = 2^(W-1)
//    handled as unsigned W-bit value.
//  - flush has priority over start and over BUSY progress; flush in DONE is ignored (result already committed).
//  - Reset mid-operation: abort to IDLE next edge, hi/lo cleared, no done pulse.
//  - Back-to-back multiplies: second start seen in IDLE cycle after DONE; no extra bubble beyond that cycle.
// CONFIGURATION
//  MUL_EARLY_EXIT_EN defined: in BUSY, after the step, if the remaining (shifted) multiplier is zero go to
//   DONE immediately; BUSY lasts (index of highest set bit of |b|)+1 cycles, min 1 (b=0 -> 1 BUSY cycle).
//  MUL_EARLY_EXIT_EN undefined: BUSY always exactly WIDTH cycles, data-independent latency.
//  Product value identical in both builds.
// TESTING
//  1. Unsigned a=3,b=5, start held -> stall_req high 33 cycles, done at cycle 33, hi=0x0, lo=0xF.
//  2. Signed a=0xFFFFFFFE(-2), b=3 -> hi=0xFFFFFFFF, lo=0xFFFFFFFA; signed 0x80000000*0x80000000 -> hi=0x40000000, lo=0.
//  3. Unsigned 0xFFFFFFFF*0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001; same operands signed -> hi=0, lo=1.
//  4. flush=1 in BUSY cycle 10 -> stall_req low next cycle, no done, hi/lo unchanged from prior result.
//  5. Reset=1 in BUSY cycle 5 -> IDLE, stall_req=0, hi=lo=0, no done; then new start completes normally.
//  6. MUL_EARLY_EXIT_EN: a=7,b=1 -> 1 BUSY cycle, done at cycle 2, lo=7; without macro done at cycle 33.

Source files
------------

// File: rtl/mul_stall_unit.sv
// Iterative radix-2 shift-add multiplier that holds the pipeline stall (MulOp) until hi/lo are ready.
// Optional feature: define MUL_EARLY_EXIT_EN to finish as soon as the remaining multiplier is zero.
module mul_stall_unit #(
  parameter int WIDTH = 32
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             start,
  input  logic             signed_op,
  input  logic             flush,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             stall_req,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  state_e               state_q, state_d;
  logic [2*WIDTH-1:0]   mcand_q, mcand_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]     mplier_q, mplier_d;
  logic [WIDTH-1:0]     hi_q, hi_d;
  logic [WIDTH-1:0]     lo_q, lo_d;
  logic [CW-1:0]        count_q, count_d;
  logic                 sign_q, sign_d;
  logic                 done_q, done_d;

  logic [WIDTH-1:0]     a_mag, b_mag;
  logic [2*WIDTH-1:0]   step_acc, product;
  logic                 last_step;

  // The most-negative operand negates to itself, which read as unsigned is exactly its magnitude.
  assign a_mag = (signed_op && a[WIDTH-1]) ? -a : a;
  assign b_mag = (signed_op && b[WIDTH-1]) ? -b : b;

  assign step_acc = acc_q + (mplier_q[0] ? mcand_q : '0);
  assign product  = sign_q ? -step_acc : step_acc;

`ifdef MUL_EARLY_EXIT_EN
  assign last_step = ((mplier_q >> 1) == '0) || (count_q == CW'(WIDTH - 1));
`else
  assign last_step = (count_q == CW'(WIDTH - 1));
`endif

  always_comb begin
    // NOTE: every _d gets a default before the case so no path leaves a variable unassigned (no latches).
    state_d  = state_q;
    mcand_d  = mcand_q;
    acc_d    = acc_q;
    mplier_d = mplier_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    count_d  = count_q;
    sign_d   = sign_q;
    done_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start && !flush) begin
          mcand_d  = {{WIDTH{1'b0}}, a_mag};
          mplier_d = b_mag;
          acc_d    = '0;
          count_d  = '0;
          sign_d   = signed_op & (a[WIDTH-1] ^ b[WIDTH-1]);
          state_d  = BUSY;
        end
      end
      BUSY: begin
        if (flush) begin
          state_d = IDLE;
        end else begin
          acc_d    = step_acc;
          mcand_d  = mcand_q << 1;
          mplier_d = mplier_q >> 1;
          count_d  = count_q + CW'(1);
          // hi/lo are loaded on entry to DONE so they are valid alongside the done strobe.
          if (last_step) begin
            state_d = DONE;
            hi_d    = product[2*WIDTH-1:WIDTH];
            lo_d    = product[WIDTH-1:0];
            done_d  = 1'b1;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q  <= IDLE;
      mcand_q  <= '0;
      acc_q    <= '0;
      mplier_q <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      count_q  <= '0;
      sign_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      acc_q    <= acc_d;
      mplier_q <= mplier_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      count_q  <= count_d;
      sign_q   <= sign_d;
      done_q   <= done_d;
    end
  end

  // Combinational so the hazard unit freezes the pipeline in the issue cycle itself.
  assign stall_req = !Reset && (((state_q == IDLE) && start && !flush) || (state_q == BUSY));
  assign done      = done_q;
  assign hi        = hi_q;
  assign lo        = lo_q;

endmodule

// File: tb/tb_mul_stall_unit.sv
// Directed self-checking bench for mul_stall_unit; latency expectations follow MUL_EARLY_EXIT_EN if defined.
module tb_mul_stall_unit;
  localparam int W = 32;

  logic         Clk = 1'b0;
  logic         Reset, start, signed_op, flush;
  logic [W-1:0] a, b;
  logic         stall_req, done;
  logic [W-1:0] hi, lo;

  int checks = 0;
  int errors = 0;

  always #5 Clk = ~Clk;

  mul_stall_unit #(.WIDTH(W)) dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .start     (start),
    .signed_op (signed_op),
    .flush     (flush),
    .a         (a),
    .b         (b),
    .stall_req (stall_req),
    .done      (done),
    .hi        (hi),
    .lo        (lo)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // Expected number of BUSY cycles for a given multiplier operand.
  function automatic int exp_busy(input logic [W-1:0] bv, input logic s);
    logic [W-1:0] m;
    int           n;
    m = (s && bv[W-1]) ? -bv : bv;
`ifdef MUL_EARLY_EXIT_EN
    n = 1;
    for (int i = 0; i < W; i++) if (m[i]) n = i + 1;
`else
    n = W;
`endif
    return n;
  endfunction

  // Issues one multiply in the current (IDLE) cycle, holds start through DONE, checks latency and result.
  task automatic run_mul(input string tag, input logic [W-1:0] av, input logic [W-1:0] bv, input logic s,
                         input logic [W-1:0] exp_hi, input logic [W-1:0] exp_lo, input bit flush_in_done);
    int cyc, stalls, busy;
    busy      = exp_busy(bv, s);
    a         = av;
    b         = bv;
    signed_op = s;
    start     = 1'b1;
    flush     = 1'b0;
    cyc       = 0;
    stalls    = 0;
    #1;
    while (!done && cyc < 100) begin
      if (stall_req) stalls++;
      tick();
      cyc++;
    end
    check({tag, " done_cycle"}, 64'(cyc), 64'(busy + 1));
    check({tag, " stall_cycles"}, 64'(stalls), 64'(busy + 1));
    check({tag, " stall_in_done"}, 64'(stall_req), 64'(0));
    check({tag, " hi"}, 64'(hi), 64'(exp_hi));
    check({tag, " lo"}, 64'(lo), 64'(exp_lo));
    flush = flush_in_done;
    tick();
    start = 1'b0;
    flush = 1'b0;
    #1;
    check({tag, " no_retrigger"}, 64'(stall_req), 64'(0));
    check({tag, " done_one_cycle"}, 64'(done), 64'(0));
    check({tag, " hi_hold"}, 64'(hi), 64'(exp_hi));
    check({tag, " lo_hold"}, 64'(lo), 64'(exp_lo));
  endtask

  initial begin
    int pulses;

    // Reset: outputs cleared and stall forced low even with start asserted.
    Reset = 1'b1; start = 1'b1; signed_op = 1'b0; flush = 1'b0; a = 32'd9; b = 32'd9;
    #1;
    check("reset stall_forced", 64'(stall_req), 64'(0));
    tick();
    tick();
    check("reset hi", 64'(hi), 64'(0));
    check("reset lo", 64'(lo), 64'(0));
    check("reset done", 64'(done), 64'(0));
    Reset = 1'b0;
    start = 1'b0;
    #1;
    check("idle stall", 64'(stall_req), 64'(0));
    tick();

    // Products, including back-to-back issues (each run starts in the IDLE cycle after the previous DONE).
    run_mul("u_3x5",       32'd3,        32'd5,        1'b0, 32'h0,        32'hF,        1'b0);
    run_mul("s_m2x3",      32'hFFFFFFFE, 32'd3,        1'b1, 32'hFFFFFFFF, 32'hFFFFFFFA, 1'b0);
    run_mul("s_min_sq",    32'h80000000, 32'h80000000, 1'b1, 32'h40000000, 32'h0,        1'b0);
    run_mul("u_max_sq",    32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 32'hFFFFFFFE, 32'h00000001, 1'b0);
    run_mul("s_m1_sq",     32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'h0,        32'h1,        1'b0);
    run_mul("u_7x1",       32'd7,        32'd1,        1'b0, 32'h0,        32'h7,        1'b0);
    run_mul("s_5xm7",      32'd5,        32'hFFFFFFF9, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFDD, 1'b0);
    run_mul("u_2p16_sq",   32'h00010000, 32'h00010000, 1'b0, 32'h1,        32'h0,        1'b0);
    run_mul("u_x0",        32'h12345678, 32'h0,        1'b0, 32'h0,        32'h0,        1'b0);
    // flush in the DONE cycle must not disturb the committed result.
    run_mul("u_flush_done", 32'h0000ABCD, 32'h00001000, 1'b0, 32'h0,       32'h0ABCD000, 1'b1);

    // flush in BUSY cycle 10 aborts without a result.
    a = 32'h00001234; b = 32'hFFFF0000; signed_op = 1'b0; start = 1'b1; flush = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    check("flush busy_stall", 64'(stall_req), 64'(1));
    flush = 1'b1;
    start = 1'b0;
    tick();
    flush = 1'b0;
    #1;
    check("flush stall_released", 64'(stall_req), 64'(0));
    check("flush no_done", 64'(done), 64'(0));
    check("flush hi_kept", 64'(hi), 64'(0));
    check("flush lo_kept", 64'(lo), 64'(32'h0ABCD000));
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (done) pulses++;
    end
    check("flush no_late_done", 64'(pulses), 64'(0));

    // flush together with start in IDLE: no issue.
    start = 1'b1; flush = 1'b1;
    #1;
    check("flush_idle stall", 64'(stall_req), 64'(0));
    tick();
    start = 1'b0; flush = 1'b0;
    #1;
    check("flush_idle not_busy", 64'(stall_req), 64'(0));
    tick();

    // Reset in BUSY cycle 5 aborts and clears hi/lo.
    a = 32'h00010000; b = 32'h00010000; signed_op = 1'b0; start = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    Reset = 1'b1;
    #1;
    check("midreset stall_forced", 64'(stall_req), 64'(0));
    tick();
    check("midreset hi", 64'(hi), 64'(0));
    check("midreset lo", 64'(lo), 64'(0));
    check("midreset done", 64'(done), 64'(0));
    Reset = 1'b0;
    start = 1'b0;
    #1;
    check("midreset idle", 64'(stall_req), 64'(0));
    tick();
    run_mul("post_reset", 32'd1000, 32'd1000, 1'b0, 32'h0, 32'd1000000, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
